// File: rtl/core_mem_arbiter.sv
// ============================================================================
//  Module   : core_mem_arbiter
//  Purpose  : Round-robin 2:1 arbiter sharing one memory port between the
//             iram and dram request interfaces, with in-order read steering.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module core_mem_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_req,
    input  logic                 i_write,
    input  logic [`XLEN/8-1:0]   i_wstrb,
    input  logic [`XLEN-1:0]     i_addr,
    input  logic [`XLEN-1:0]     i_wdata,
    output logic                 i_ready,
    output logic                 i_rvalid,
    output logic [`XLEN-1:0]     i_rdata,

    input  logic                 d_req,
    input  logic                 d_write,
    input  logic [`XLEN/8-1:0]   d_wstrb,
    input  logic [`XLEN-1:0]     d_addr,
    input  logic [`XLEN-1:0]     d_wdata,
    output logic                 d_ready,
    output logic                 d_rvalid,
    output logic [`XLEN-1:0]     d_rdata,

    output logic                 m_req,
    output logic                 m_write,
    output logic [`XLEN/8-1:0]   m_wstrb,
    output logic [`XLEN-1:0]     m_addr,
    output logic [`XLEN-1:0]     m_wdata,
    input  logic                 m_ready,
    input  logic                 m_rvalid,
    input  logic [`XLEN-1:0]     m_rdata,

    output logic                 err_rvalid
);

    localparam int                 C_CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [C_CNT_W-1:0] C_MAX   = C_CNT_W'(OUTSTANDING);
    localparam logic               C_SIDE_I = 1'b0;
    localparam logic               C_SIDE_D = 1'b1;

    logic                   r_lock;
    logic                   r_lock_owner;
    logic                   r_last;
    logic [OUTSTANDING-1:0] r_fifo;      // owner tags, head at bit 0
    logic [C_CNT_W-1:0]     r_count;
    logic                   r_err_rvalid;

    logic                   w_full;
    logic                   w_i_elig;
    logic                   w_d_elig;
    logic                   w_grant;
    logic                   w_m_req;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic [C_CNT_W-1:0]     w_wr_idx;
    logic [OUTSTANDING-1:0] w_fifo_next;

    assign w_full   = (r_count == C_MAX);
    assign w_i_elig = i_req & (i_write | ~w_full);
    assign w_d_elig = d_req & (d_write | ~w_full);

    // A held grant follows the owner's req so a dropped request cannot wedge the lock.
    always_comb begin
        w_grant = C_SIDE_I;
        w_m_req = 1'b0;
        if (r_lock) begin
            w_grant = r_lock_owner;
            w_m_req = r_lock_owner ? d_req : i_req;
        end else if (w_i_elig && w_d_elig) begin
            w_grant = ~r_last;
            w_m_req = 1'b1;
        end else if (w_d_elig) begin
            w_grant = C_SIDE_D;
            w_m_req = 1'b1;
        end else if (w_i_elig) begin
            w_grant = C_SIDE_I;
            w_m_req = 1'b1;
        end
    end

    assign m_req   = w_m_req;
    assign m_write = w_grant ? d_write : i_write;
    assign m_wstrb = w_grant ? d_wstrb : i_wstrb;
    assign m_addr  = w_grant ? d_addr  : i_addr;
    assign m_wdata = w_grant ? d_wdata : i_wdata;

    assign i_ready = w_m_req & ~w_grant & m_ready;
    assign d_ready = w_m_req &  w_grant & m_ready;

    assign w_accept = w_m_req & m_ready;
    assign w_push   = w_accept & ~m_write;
    assign w_pop    = m_rvalid & (r_count != '0);

    assign i_rvalid = w_pop & ~r_fifo[0];
    assign d_rvalid = w_pop &  r_fifo[0];
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    // On a simultaneous pop the new tag lands one slot lower after the shift.
    assign w_wr_idx = w_pop ? (r_count - C_CNT_W'(1)) : r_count;

    always_comb begin
        w_fifo_next = r_fifo;
        if (w_pop) begin
            w_fifo_next = r_fifo >> 1;
        end
        for (int k = 0; k < OUTSTANDING; k++) begin
            if (w_push && (w_wr_idx == C_CNT_W'(k))) begin
                w_fifo_next[k] = w_grant;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock       <= 1'b0;
            r_lock_owner <= C_SIDE_I;
            r_last       <= C_SIDE_I;
            r_fifo       <= '0;
            r_count      <= '0;
            r_err_rvalid <= 1'b0;
        end else begin
            r_lock <= w_m_req & ~m_ready;
            if (w_m_req && !m_ready) begin
                r_lock_owner <= w_grant;
            end
            if (w_accept) begin
                r_last <= w_grant;
            end
            r_fifo <= w_fifo_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (m_rvalid && (r_count == '0)) begin
                r_err_rvalid <= 1'b1;
            end
        end
    end

    assign err_rvalid = r_err_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: expected accepts and read beats are
// queued by the stimulus and retired by a negedge monitor.
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module tb_core_mem_arbiter;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_req, i_write, d_req, d_write;
    logic [`XLEN/8-1:0]   i_wstrb, d_wstrb, m_wstrb;
    logic [`XLEN-1:0]     i_addr, i_wdata, d_addr, d_wdata;
    logic                 i_ready, i_rvalid, d_ready, d_rvalid;
    logic [`XLEN-1:0]     i_rdata, d_rdata;
    logic                 m_req, m_write, m_ready, m_rvalid;
    logic [`XLEN-1:0]     m_addr, m_wdata, m_rdata;
    logic                 err_rvalid;

    core_mem_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_write(i_write), .i_wstrb(i_wstrb), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_write(m_write), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .err_rvalid(err_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             side;
        logic             wr;
        logic [`XLEN-1:0] addr;
        logic [`XLEN-1:0] wdata;
    } acc_t;

    typedef struct packed {
        logic             side;
        logic [`XLEN-1:0] data;
    } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_acc(input logic side, input logic wr,
                            input logic [`XLEN-1:0] addr, input logic [`XLEN-1:0] wdata);
        acc_t e;
        e.side = side; e.wr = wr; e.addr = addr; e.wdata = wdata;
        exp_acc.push_back(e);
    endtask

    task automatic push_rsp(input logic side, input logic [`XLEN-1:0] data);
        rsp_t e;
        e.side = side; e.data = data;
        exp_rsp.push_back(e);
    endtask

    // Monitor: retires one expected accept per downstream handshake and one
    // expected beat per returned rvalid.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_req && m_ready) begin
                if (exp_acc.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_accept: addr %h", m_addr);
                end else begin
                    acc_t e;
                    e = exp_acc.pop_front();
                    check("acc_side", {63'd0, d_ready}, {63'd0, e.side});
                    check("acc_write", {63'd0, m_write}, {63'd0, e.wr});
                    check("acc_addr", 64'(m_addr), 64'(e.addr));
                    if (e.wr) check("acc_wdata", 64'(m_wdata), 64'(e.wdata));
                end
            end
            if (i_rvalid || d_rvalid) begin
                if (exp_rsp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rvalid: i=%b d=%b", i_rvalid, d_rvalid);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    check("rsp_onehot", {62'd0, i_rvalid, d_rvalid},
                          r.side ? 64'd1 : 64'd2);
                    check("rsp_data", 64'(r.side ? d_rdata : i_rdata), 64'(r.data));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_req = 0; i_write = 0; i_wstrb = '0; i_addr = '0; i_wdata = '0;
        d_req = 0; d_write = 0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
        step();
        @(negedge clk);
        check("rst_m_req", {63'd0, m_req}, 64'd0);
        check("rst_ready", {62'd0, i_ready, d_ready}, 64'd0);
        check("rst_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        check("rst_err", {63'd0, err_rvalid}, 64'd0);
        step();
        rst = 1'b0;

        // Tie-break: first tie after reset goes to D.
        i_req = 1; i_write = 0; i_addr = 32'h100;
        d_req = 1; d_write = 0; d_addr = 32'h200;
        m_ready = 1;
        push_acc(1'b1, 1'b0, 32'h200, '0);
        push_acc(1'b0, 1'b0, 32'h100, '0);
        @(negedge clk);
        check("tie_addr0", 64'(m_addr), 64'h200);
        step();
        d_req = 0;
        @(negedge clk);
        check("tie_addr1", 64'(m_addr), 64'h100);
        step();
        i_req = 0;
        push_rsp(1'b1, 32'hAAAA_0001);
        push_rsp(1'b0, 32'hBBBB_0002);
        m_rvalid = 1; m_rdata = 32'hAAAA_0001;
        step();
        m_rdata = 32'hBBBB_0002;
        step();
        m_rvalid = 0;

        // Lone D write so that last=D before the stall.
        d_req = 1; d_write = 1; d_addr = 32'h3C; d_wdata = 32'h1111_2222; d_wstrb = 4'hF;
        push_acc(1'b1, 1'b1, 32'h3C, 32'h1111_2222);
        step();

        // Stall lock: D write held for 3 cycles while I arrives.
        d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; m_ready = 0;
        push_acc(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        @(negedge clk);
        check("lock_addr_c0", 64'(m_addr), 64'h40);
        step();
        i_req = 1; i_write = 0; i_addr = 32'h104;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            check("lock_addr", 64'(m_addr), 64'h40);
            check("lock_i_ready", {63'd0, i_ready}, 64'd0);
            step();
        end
        m_ready = 1;
        @(negedge clk);
        check("lock_release_d_ready", {63'd0, d_ready}, 64'd1);
        check("lock_release_i_ready", {63'd0, i_ready}, 64'd0);
        step();
        d_req = 0; d_write = 0;
        push_acc(1'b0, 1'b0, 32'h104, '0);
        step();
        i_req = 0;
        push_rsp(1'b0, 32'hCCCC_0003);
        m_rvalid = 1; m_rdata = 32'hCCCC_0003;
        step();
        m_rvalid = 0;

        // FIFO full: two I reads outstanding, third blocked, D write passes.
        i_req = 1; i_write = 0; i_addr = 32'h300;
        push_acc(1'b0, 1'b0, 32'h300, '0);
        step();
        i_addr = 32'h304;
        push_acc(1'b0, 1'b0, 32'h304, '0);
        step();
        i_addr = 32'h308;
        d_req = 1; d_write = 1; d_addr = 32'h500; d_wdata = 32'h5555_5555;
        push_acc(1'b1, 1'b1, 32'h500, 32'h5555_5555);
        @(negedge clk);
        check("full_i_ready_w", {63'd0, i_ready}, 64'd0);
        step();
        d_req = 0; d_write = 0;
        @(negedge clk);
        check("full_m_req", {63'd0, m_req}, 64'd0);
        check("full_i_ready", {63'd0, i_ready}, 64'd0);
        step();
        m_rvalid = 1; m_rdata = 32'hEEEE_0004;
        push_rsp(1'b0, 32'hEEEE_0004);
        @(negedge clk);
        check("full_pop_cycle_m_req", {63'd0, m_req}, 64'd0);
        step();
        m_rvalid = 0;
        push_acc(1'b0, 1'b0, 32'h308, '0);
        @(negedge clk);
        check("full_after_pop_i_ready", {63'd0, i_ready}, 64'd1);
        step();
        i_req = 0;
        push_rsp(1'b0, 32'hF0F0_0005);
        push_rsp(1'b0, 32'hF0F0_0006);
        m_rvalid = 1; m_rdata = 32'hF0F0_0005;
        step();
        m_rdata = 32'hF0F0_0006;
        step();
        m_rvalid = 0;

        // Simultaneous push and pop with one D read outstanding.
        d_req = 1; d_write = 0; d_addr = 32'h600;
        push_acc(1'b1, 1'b0, 32'h600, '0);
        step();
        d_req = 0;
        i_req = 1; i_write = 0; i_addr = 32'h700;
        push_acc(1'b0, 1'b0, 32'h700, '0);
        push_rsp(1'b1, 32'h1234_5678);
        m_rvalid = 1; m_rdata = 32'h1234_5678;
        step();
        i_req = 0;
        push_rsp(1'b0, 32'h8765_4321);
        m_rdata = 32'h8765_4321;
        step();
        m_rvalid = 0;

        // Spurious rvalid with nothing outstanding.
        m_rvalid = 1; m_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        check("spur_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        check("spur_err_same_cycle", {63'd0, err_rvalid}, 64'd0);
        step();
        m_rvalid = 0;
        @(negedge clk);
        check("spur_err_set", {63'd0, err_rvalid}, 64'd1);
        step();
        @(negedge clk);
        check("spur_err_held", {63'd0, err_rvalid}, 64'd1);
        step();

        // Reset mid-operation: two reads outstanding plus a locked write.
        i_req = 1; i_write = 0; i_addr = 32'h800; m_ready = 1;
        push_acc(1'b0, 1'b0, 32'h800, '0);
        step();
        i_req = 0;
        d_req = 1; d_write = 0; d_addr = 32'h900;
        push_acc(1'b1, 1'b0, 32'h900, '0);
        step();
        d_write = 1; d_addr = 32'hA00; m_ready = 0;
        step();
        rst = 1;
        i_req = 0; d_req = 0; d_write = 0; m_ready = 0; m_rvalid = 0;
        #1;
        check("mid_rst_m_req", {63'd0, m_req}, 64'd0);
        check("mid_rst_ready", {62'd0, i_ready, d_ready}, 64'd0);
        check("mid_rst_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        check("mid_rst_err", {63'd0, err_rvalid}, 64'd0);
        step();
        rst = 0;
        m_rvalid = 1; m_rdata = 32'hCAFE_CAFE;
        @(negedge clk);
        check("late_beat_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        step();
        m_rvalid = 0;
        @(negedge clk);
        check("late_beat_err", {63'd0, err_rvalid}, 64'd1);
        step();

        check("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
        check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Two-to-one arbiter that shares a single external memory port between the core's instruction-RAM and data-RAM request interfaces. It sits between the core's iram/dram ports and the unified memory bus. Both sides use the core's req/ready/rvalid protocol on each side. It grants requests round-robin, holds a grant stable while the downstream port stalls, and tracks outstanding reads in order so each rvalid/rdata beat is steered back to the requester that issued it.

## Interface
- OUTSTANDING, 2: maximum in-flight reads across both requesters (1..8); sets the depth of the read-ID FIFO.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_req, i_write  in  1  instruction-side request and write flag.
- i_wstrb  in  `XLEN/8  instruction-side byte strobes.
- i_addr, i_wdata  in  `XLEN  instruction-side address and write data.
- i_ready  out  1  instruction-side request accepted this cycle.
- i_rvalid  out  1  instruction-side read data valid.
- i_rdata  out  `XLEN  instruction-side read data.
- d_req, d_write, d_wstrb, d_addr, d_wdata, d_ready, d_rvalid, d_rdata: data side, with the same widths and meanings as the i_* ports.
- m_req, m_write  out  1  downstream request and write flag.
- m_wstrb  out  `XLEN/8  downstream byte strobes.
- m_addr, m_wdata  out  `XLEN  downstream address and write data.
- m_ready  in  1  downstream accepted the request.
- m_rvalid  in  1  downstream read data valid.
- m_rdata  in  `XLEN  downstream read data.
- err_rvalid  out  1  sticky flag: m_rvalid arrived with no outstanding read.

## Operation
- **Handshake.** A transfer occurs on a requester when its req=1 and its ready=1 in the same cycle. Writes produce no response. Each read produces exactly one rvalid beat, returned in issue order.
- **State.**
  - `lock` and `lock_owner`: grant hold.
  - `last`: the last requester granted.
  - Read-ID FIFO of 1-bit owner tags (0=I, 1=D), with `count` of width $clog2(OUTSTANDING+1).
- **Eligibility.** A requester is eligible when its req=1 and either it is a write, or it is a read and count < OUTSTANDING. A read seen while the FIFO is full is not eligible.
- **Grant selection.**
  - If lock=1, the grant goes to lock_owner.
  - Otherwise, if exactly one requester is eligible, that requester is granted.
  - If both are eligible, the one that is not `last` is granted (round-robin).
  - If none is eligible, m_req=0.
- **Muxing.** m_req/m_write/m_wstrb/m_addr/m_wdata are driven from the granted requester. m_* data is don't-care when m_req=0.
- **Ready.** The granted requester's ready = m_ready. The non-granted requester's ready = 0.
- **Lock.** When m_req=1 and m_ready=0: set lock=1 and lock_owner=grant. Clear lock on acceptance (m_req & m_ready).
  - A locked request keeps its grant even if the other side becomes eligible.
  - A locked read stays granted even if the FIFO is full; this cannot occur, because eligibility was checked before the lock was taken.
- **On acceptance.** `last` := grant. If the transfer is a read, push the grant tag into the FIFO.
- **Response routing.** When m_rvalid=1 and count>0: pop the FIFO head, assert {head}_rvalid=1, and drive m_rdata on {head}_rdata. The other side's rvalid=0.
- **Spurious rvalid.** When m_rvalid=1 and count=0: the beat is dropped and err_rvalid:=1. err_rvalid clears only on reset.
- **Simultaneous push and pop.** Both are applied and count is unchanged. A push when count=OUTSTANDING never happens, because the read was not eligible.
- **Reset.** Asynchronous. Clears the FIFO, count=0, lock=0, last=I (so the first tie grants D), err_rvalid=0.
  - Requests or reads in flight at reset are abandoned.
  - Late m_rvalid beats after reset count as spurious.

## Timing
- The request path is combinational: zero added cycles from {i,d}_req to m_req, and from m_ready to {i,d}_ready.
- The response path is combinational: zero added cycles from m_rvalid/m_rdata to {i,d}_rvalid/rdata.
- Downstream read latency must be at least 1 cycle after acceptance. An m_rvalid in the acceptance cycle pairs with an older entry, or is spurious.
- Full throughput: one accepted transfer per cycle when m_ready=1.
- Output values during and after reset, with all inputs 0:
  - m_req=0.
  - i_ready=d_ready=0.
  - i_rvalid=d_rvalid=0.
  - err_rvalid=0.
- The only registered outputs are err_rvalid and the internal grant/FIFO state.

## Test plan
- **Tie-break, OUTSTANDING=2.** After reset, both sides issue reads, addr I=0x100 and D=0x200, with m_ready=1.
  - Cycle 0 grants D (m_addr=0x200); cycle 1 grants I (0x100).
  - m_rvalid with rdata A then B → d_rvalid with A, then i_rvalid with B.
- **Stall lock.** D issues a write to 0x40 with m_ready=0 for 3 cycles, and I raises req in cycle 1.
  - m_addr stays 0x40 and i_ready=0 throughout.
  - When m_ready=1, D is accepted, and the next cycle grants I.
- **FIFO full.** Two I reads are accepted with no m_rvalid.
  - A third I read → m_req=0 and i_ready=0.
  - A concurrent D write is still accepted.
  - One m_rvalid → count=1, and the next I read is granted.
- **Simultaneous push and pop.** count=1 (D). An I read is accepted in the same cycle as an m_rvalid.
  - d_rvalid=1 and count stays 1.
  - The next m_rvalid → i_rvalid.
- **Spurious rvalid.** m_rvalid=1 with count=0.
  - i_rvalid=d_rvalid=0, and err_rvalid=1 from the next cycle onward, held.
- **Reset mid-operation.** Assert rst while count=2 and lock=1.
  - All outputs go to their reset values immediately.
  - After release, an m_rvalid sets err_rvalid.
